uart_tx_fifo: RTL and testbench

Buffered feeder placed directly upstream of the UART transmitter. Accepts bytes from the CPU/peripheral bus into a circular FIFO. Drains the FIFO one byte at a time into the transmitter using its en/busy handshake, so software can queue bursts without polling busy per byte. Provides level and overflow status for the peripheral register file.

---
 rtl/uart_tx_fifo.sv | 96 +++++++++
 tb/tb_uart_tx_fifo.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO that feeds the UART transmitter one byte at a time
// over its en/busy handshake, with level and sticky overflow status.
module uart_tx_fifo #(
  parameter int DATA_W     = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  hold,
  input  logic                  clr_ovf,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic                  tx_en,
  output logic [DATA_W-1:0]     tx_data,
  input  logic                  tx_busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   level_q;
  state_t                state;
  logic                  push;
  logic                  pop;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);
  assign level = level_q;

  // full/empty come from the pre-edge level, so a write while full is
  // dropped even if a pop happens on the same edge
  assign push = wr_en && !full;
  assign pop  = (state == IDLE) && !empty && !tx_busy && !hold;

  // Storage carries no reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
      // A dropped write outranks a same-cycle clear
      if (wr_en && full)  overflow <= 1'b1;
      else if (clr_ovf)   overflow <= 1'b0;
    end
  end

  // Send sequencer: tx_en is a registered single-cycle strobe, and the
  // busy rise/fall pair must be seen before the next byte is issued
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx_en   <= 1'b0;
      tx_data <= '0;
    end else begin
      tx_en <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data <= mem[rd_ptr];
            tx_en   <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE:     state <= WAIT_BUSY;
        WAIT_BUSY: if (tx_busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!tx_busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: a behavioural transmitter model records
// every issued byte, and table vectors plus hand sequences check status.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       hold;
  logic       clr_ovf;
  logic       full;
  logic       empty;
  logic [4:0] level;
  logic       overflow;
  logic       tx_en;
  logic [7:0] tx_data;
  logic       tx_busy = 1'b0;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  logic [7:0] rx_q[$];

  typedef struct {
    logic       wr_en;
    logic [7:0] wr_data;
    logic       hold;
    logic       clr_ovf;
    logic       exp_full;
    logic       exp_empty;
    logic [4:0] exp_level;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[21];

  uart_tx_fifo #(.DATA_W(8), .DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .hold(hold), .clr_ovf(clr_ovf), .full(full), .empty(empty),
    .level(level), .overflow(overflow), .tx_en(tx_en), .tx_data(tx_data),
    .tx_busy(tx_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transmitter model: busy for three cycles after each strobe
  always @(negedge clk) begin
    if (tx_en) begin
      chk("en_while_busy", tx_busy, 0);
      rx_q.push_back(tx_data);
      busy_cnt = 3;
    end else if (busy_cnt > 0) begin
      busy_cnt--;
    end
    tx_busy = (busy_cnt != 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_rx(input int n);
    for (int i = 0; i < 2000; i++) begin
      if (rx_q.size() >= n) break;
      @(negedge clk);
    end
    chk("rx_timeout", rx_q.size() >= n, 1);
  endtask

  task automatic push_byte(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  int base;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; hold = 1'b0; clr_ovf = 1'b0;

    for (int i = 0; i < 17; i++) begin
      vecs[i].wr_en     = 1'b1;
      vecs[i].wr_data   = 8'(i);
      vecs[i].hold      = 1'b1;
      vecs[i].clr_ovf   = 1'b0;
      vecs[i].exp_full  = (i >= 15);
      vecs[i].exp_empty = 1'b0;
      vecs[i].exp_level = (i >= 15) ? 5'd16 : 5'(i + 1);
      vecs[i].exp_ovf   = (i == 16);
    end
    vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 5'd16, 1'b1};
    vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 5'd16, 1'b0};
    vecs[19] = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b1, 1'b0, 5'd16, 1'b1};
    vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 5'd16, 1'b0};

    // Reset state
    cyc(2);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_tx_en", tx_en, 0);
    chk("rst_tx_data", tx_data, 0);
    reset = 1'b0;
    cyc(1);

    // Single byte latency
    wr_en = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_en = 1'b0;
    chk("single_level_c1", level, 1);
    chk("single_en_c1", tx_en, 0);
    @(negedge clk);
    chk("single_en_c2", tx_en, 1);
    chk("single_data_c2", tx_data, 8'hA5);
    chk("single_level_c2", level, 0);
    @(negedge clk);
    chk("single_en_c3", tx_en, 0);
    wait_rx(1);
    cyc(10);
    chk("single_rx", rx_q[0], 8'hA5);

    // Burst of three
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    wait_rx(4);
    cyc(40);
    chk("burst_count", rx_q.size(), 4);
    for (int i = 0; i < 3; i++) chk("burst_order", rx_q[1 + i], 32'(i + 1));
    chk("burst_tx_data_held", tx_data, 8'h03);

    // Full / overflow table
    for (int i = 0; i < 21; i++) begin
      wr_en = vecs[i].wr_en; wr_data = vecs[i].wr_data;
      hold = vecs[i].hold; clr_ovf = vecs[i].clr_ovf;
      @(negedge clk);
      chk($sformatf("vec%0d_full", i), full, vecs[i].exp_full);
      chk($sformatf("vec%0d_empty", i), empty, vecs[i].exp_empty);
      chk($sformatf("vec%0d_level", i), level, vecs[i].exp_level);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].exp_ovf);
    end
    wr_en = 1'b0; clr_ovf = 1'b0;
    base = rx_q.size();
    chk("hold_no_send", base, 4);
    hold = 1'b0;
    wait_rx(base + 16);
    cyc(40);
    chk("ovf_drain_count", rx_q.size(), base + 16);
    for (int i = 0; i < 16; i++) chk("ovf_drain_order", rx_q[base + i], 32'(i));
    chk("ovf_drain_empty", empty, 1);

    // Wrap and simultaneous push/pop
    base = rx_q.size();
    hold = 1'b1;
    for (int i = 0; i < 16; i++) push_byte(8'h40 + 8'(i));
    chk("wrap_level16", level, 16);
    hold = 1'b0;
    wait_rx(base + 10);
    hold = 1'b1;
    cyc(12);
    chk("wrap_drain10", rx_q.size(), base + 10);
    chk("wrap_level6", level, 6);
    for (int i = 0; i < 9; i++) push_byte(8'h50 + 8'(i));
    chk("wrap_level15", level, 15);
    hold = 1'b0; wr_en = 1'b1; wr_data = 8'h59;
    @(negedge clk);
    wr_en = 1'b0;
    chk("pushpop_level", level, 15);
    chk("pushpop_en", tx_en, 1);
    wait_rx(base + 26);
    cyc(40);
    chk("wrap_count", rx_q.size(), base + 26);
    for (int i = 0; i < 26; i++) chk("wrap_order", rx_q[base + i], 32'h40 + 32'(i));

    // Reset while waiting for byte 2 to finish
    base = rx_q.size();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) push_byte(8'h60 + 8'(i));
    hold = 1'b0;
    wait_rx(base + 2);
    cyc(2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_level", level, 0);
    chk("midrst_empty", empty, 1);
    chk("midrst_en", tx_en, 0);
    cyc(30);
    chk("midrst_no_send", rx_q.size(), base + 2);
    chk("midrst_order", rx_q[base + 1], 8'h61);
    push_byte(8'h77);
    wait_rx(base + 3);
    cyc(10);
    chk("post_rst_send", rx_q[base + 2], 8'h77);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
